// File: rtl/delay_scan_controller_pkg.sv
// Shared types and constants for the delay-scan controller.
// Contents:
//   DW_DEFAULT      default delay code width
//   scan_state_e    controller FSM states
//   scan_cfg_t      scan configuration bundle (also used by the SPI command decoder)
//   eff_repeats()   repeat count with zero mapped to one run
package delay_scan_controller_pkg;

    localparam int unsigned DW_DEFAULT = 10;

    typedef enum logic [2:0] {
        StIdle,
        StProgram,
        StSettle,
        StRun,
        StWaitLow,
        StWaitHigh,
        StNext,
        StDone
    } scan_state_e;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] first;
        logic [DW_DEFAULT-1:0] last;
        logic [DW_DEFAULT-1:0] step;
        logic [7:0]            repeats;
        logic                  chip;
    } scan_cfg_t;

    // A repeat count of zero still performs one sequencer run per point.
    function automatic logic [7:0] eff_repeats(input logic [7:0] repeats);
        return (repeats == 8'd0) ? 8'd1 : repeats;
    endfunction

endpackage

// File: rtl/delay_scan_controller_if.sv
// Bus between the scan controller and the delay chip / TDC sequencer.
// Signals:
//   del_set    one-cycle pulse to delay.set
//   del_sel    delay chip select (0=A, 1=B)
//   del_d      delay code
//   seq_run    one-cycle pulse to run_sequencer
//   seq_ready  sequencer ready_flag
// Modports: master = scan controller, slave = delay/sequencer side.
interface delay_scan_controller_if #(
    parameter int unsigned DW = 10
) ();

    logic          del_set;
    logic          del_sel;
    logic [DW-1:0] del_d;
    logic          seq_run;
    logic          seq_ready;

    modport master (
        output del_set,
        output del_sel,
        output del_d,
        output seq_run,
        input  seq_ready
    );

    modport slave (
        input  del_set,
        input  del_sel,
        input  del_d,
        input  seq_run,
        output seq_ready
    );

endinterface

// File: rtl/delay_scan_controller_scan_wait_counter.sv
// Loadable down-counter with a terminal flag, shared by the settle and
// handshake-timeout waits.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   term        counter is at zero
// The counter decrements every non-load cycle and holds at zero.
module scan_wait_counter #(
    parameter int unsigned Width = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             term
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign term = (cnt_q == '0);

endmodule

// File: rtl/delay_scan_controller.sv
// Delay-vs-code scan controller. Steps the delay-chip code from cfg_first to
// cfg_last by cfg_step, programming the chip at each point, waiting for it to
// settle and then running the TDC sequencer cfg_repeats times.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start, abort   single-cycle control pulses
//   cfg_*          scan configuration, latched on start
//   bus            delay/sequencer bus (master side)
//   busy           scan in progress
//   done           one-cycle pulse on normal completion
//   timeout_err    sticky, a sequencer handshake timed out
//   point_idx      0-based index of the current point
//   run_idx        run index within the current point
module delay_scan_controller
    import delay_scan_controller_pkg::*;
#(
    parameter int unsigned DW             = DW_DEFAULT,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DW-1:0]           cfg_first,
    input  logic [DW-1:0]           cfg_last,
    input  logic [DW-1:0]           cfg_step,
    input  logic [7:0]              cfg_repeats,
    input  logic                    cfg_chip,
    delay_scan_controller_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [DW-1:0]           point_idx,
    output logic [7:0]              run_idx
);

    localparam int unsigned MaxWait =
        (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW = $clog2(MaxWait + 1);
    // The counter reads zero during the last cycle of a wait, so load N-1.
    localparam logic [CW-1:0] SettleLoad  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutLoad = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] OneDw       = DW'(1);

    scan_state_e   state_q;
    logic [DW-1:0] code_q;
    logic [DW-1:0] last_q;
    logic [DW-1:0] step_q;
    logic [7:0]    rep_q;
    logic          chip_q;
    logic          del_set_q;
    logic          del_sel_q;
    logic          seq_run_q;
    logic          done_q;
    logic          timeout_err_q;
    logic [DW-1:0] point_idx_q;
    logic [7:0]    run_idx_q;

    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_term;

    // Next code is one bit wider so an overflow past DW bits ends the scan
    // instead of wrapping to a small code.
    logic [DW:0] next_code;
    logic        last_point;
    logic        last_run;

    assign next_code  = {1'b0, code_q} + {1'b0, step_q};
    assign last_point = (step_q == '0) || next_code[DW] || (next_code[DW-1:0] > last_q);
    assign last_run   = (run_idx_q == (eff_repeats(rep_q) - 8'd1));

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state_q)
            StProgram: begin
                cnt_load = 1'b1;
                cnt_val  = SettleLoad;
            end
            StRun: begin
                cnt_load = 1'b1;
                cnt_val  = TimeoutLoad;
            end
            StWaitLow: begin
                if (!bus.seq_ready) begin
                    cnt_load = 1'b1;
                    cnt_val  = TimeoutLoad;
                end
            end
            default: ;
        endcase
    end

    scan_wait_counter #(
        .Width(CW)
    ) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_val),
        .term    (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            code_q        <= '0;
            last_q        <= '0;
            step_q        <= '0;
            rep_q         <= '0;
            chip_q        <= 1'b0;
            del_set_q     <= 1'b0;
            del_sel_q     <= 1'b0;
            seq_run_q     <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            point_idx_q   <= '0;
            run_idx_q     <= '0;
        end else begin
            del_set_q <= 1'b0;
            seq_run_q <= 1'b0;
            done_q    <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            state_q       <= StProgram;
                            code_q        <= cfg_first;
                            last_q        <= cfg_last;
                            step_q        <= cfg_step;
                            rep_q         <= cfg_repeats;
                            chip_q        <= cfg_chip;
                            del_set_q     <= 1'b1;
                            del_sel_q     <= cfg_chip;
                            timeout_err_q <= 1'b0;
                            point_idx_q   <= '0;
                            run_idx_q     <= '0;
                        end
                    end
                    StProgram: state_q <= StSettle;
                    StSettle: begin
                        if (cnt_term) begin
                            state_q   <= StRun;
                            seq_run_q <= 1'b1;
                        end
                    end
                    StRun: state_q <= StWaitLow;
                    StWaitLow: begin
                        if (!bus.seq_ready) begin
                            state_q <= StWaitHigh;
                        end else if (cnt_term) begin
                            state_q       <= StIdle;
                            timeout_err_q <= 1'b1;
                        end
                    end
                    StWaitHigh: begin
                        // A ready rising on the expiry cycle still counts.
                        if (bus.seq_ready) begin
                            state_q <= StNext;
                        end else if (cnt_term) begin
                            state_q       <= StIdle;
                            timeout_err_q <= 1'b1;
                        end
                    end
                    StNext: begin
                        if (!last_run) begin
                            state_q   <= StRun;
                            run_idx_q <= run_idx_q + 8'd1;
                            seq_run_q <= 1'b1;
                        end else if (!last_point) begin
                            state_q     <= StProgram;
                            code_q      <= next_code[DW-1:0];
                            point_idx_q <= point_idx_q + OneDw;
                            run_idx_q   <= '0;
                            del_set_q   <= 1'b1;
                            del_sel_q   <= chip_q;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Abort suppresses the pulses in the cycle it is presented.
    assign bus.del_set = del_set_q & ~abort;
    assign bus.seq_run = seq_run_q & ~abort;
    assign bus.del_sel = del_sel_q;
    assign bus.del_d   = code_q;
    assign done        = done_q & ~abort;
    assign busy        = (state_q != StIdle);
    assign timeout_err = timeout_err_q;
    assign point_idx   = point_idx_q;
    assign run_idx     = run_idx_q;

endmodule

// File: tb/tb_delay_scan_controller.sv
// Scoreboard bench for delay_scan_controller: each scan pushes its expected
// del_set / seq_run / done events; a negedge monitor pops and compares them.
module tb_delay_scan_controller;

    localparam int DW     = 10;
    localparam int SETTLE = 16;
    localparam int TMO    = 64;

    typedef struct packed {
        logic          set_f;
        logic          run_f;
        logic          done_f;
        logic [DW-1:0] d;
        logic          sel;
        logic [DW-1:0] pidx;
        logic [7:0]    ridx;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_first = '0;
    logic [DW-1:0] cfg_last = '0;
    logic [DW-1:0] cfg_step = '0;
    logic [7:0]    cfg_repeats = '0;
    logic          cfg_chip = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [DW-1:0] point_idx;
    logic [7:0]    run_idx;

    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];
    bit  stuck = 1'b0;
    int  seq_cnt = 0;

    // Monitor state
    ev_t got_ev;
    ev_t exp_ev;
    int  mon_cyc = 0;
    int  set_cyc = 0;
    bit  set_pend = 1'b0;
    bit  prev_done = 1'b0;

    delay_scan_controller_if #(.DW(DW)) bus ();

    delay_scan_controller #(
        .DW            (DW),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_first  (cfg_first),
        .cfg_last   (cfg_last),
        .cfg_step   (cfg_step),
        .cfg_repeats(cfg_repeats),
        .cfg_chip   (cfg_chip),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .point_idx  (point_idx),
        .run_idx    (run_idx)
    );

    always #5 clk = ~clk;

    // Sequencer model: ready drops 3 cycles after a run, returns 20 later.
    always @(posedge clk) begin
        if (reset) begin
            bus.seq_ready <= 1'b1;
            seq_cnt       <= 0;
        end else if (bus.seq_run && !stuck) begin
            seq_cnt <= 1;
        end else if (seq_cnt > 0) begin
            seq_cnt <= seq_cnt + 1;
            if (seq_cnt == 3) bus.seq_ready <= 1'b0;
            if (seq_cnt == 23) begin
                bus.seq_ready <= 1'b1;
                seq_cnt       <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [33:0] outs();
        return {busy, done, timeout_err, bus.del_set, bus.del_sel, bus.del_d, bus.seq_run,
                point_idx, run_idx};
    endfunction

    task automatic push_ev(input bit s, input bit r, input bit dn, input int d, input bit sel,
                           input int p, input int ri);
        ev_t e;
        e.set_f  = s;
        e.run_f  = r;
        e.done_f = dn;
        e.d      = DW'(d);
        e.sel    = sel;
        e.pidx   = DW'(p);
        e.ridx   = 8'(ri);
        exp_q.push_back(e);
    endtask

    // Reference sweep: points first, first+step, ... while <= last and < 1024.
    task automatic push_scan(input int first, input int last, input int step, input int rep,
                             input bit chip);
        int code = first;
        int p = 0;
        int eff = (rep == 0) ? 1 : rep;
        int nxt;
        while (1) begin
            push_ev(1, 0, 0, code, chip, p, 0);
            for (int r = 0; r < eff; r++) push_ev(0, 1, 0, code, chip, p, r);
            nxt = code + step;
            if (step == 0 || nxt > last || nxt > 1023) break;
            code = nxt;
            p++;
        end
        push_ev(0, 0, 1, code, chip, p, eff - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int first, input int last, input int step, input int rep,
                            input bit chip);
        cfg_first   = DW'(first);
        cfg_last    = DW'(last);
        cfg_step    = DW'(step);
        cfg_repeats = 8'(rep);
        cfg_chip    = chip;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("scan_finishes", busy, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_full(input int first, input int last, input int step, input int rep,
                            input bit chip);
        push_scan(first, last, step, rep, chip);
        do_start(first, last, step, rep, chip);
        wait_idle(3000);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (reset) begin
                set_pend  = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("busy_after_done", busy, 0);
                prev_done = done;
                if (bus.del_set || bus.seq_run || done) begin
                    got_ev.set_f  = bus.del_set;
                    got_ev.run_f  = bus.seq_run;
                    got_ev.done_f = done;
                    got_ev.d      = bus.del_d;
                    got_ev.sel    = bus.del_sel;
                    got_ev.pidx   = point_idx;
                    got_ev.ridx   = run_idx;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event got=%0h exp=none", got_ev);
                    end else begin
                        exp_ev = exp_q.pop_front();
                        check("event", got_ev, exp_ev);
                    end
                end
                if (bus.del_set) begin
                    set_cyc  = mon_cyc;
                    set_pend = 1'b1;
                end
                if (bus.seq_run && set_pend) begin
                    check("set_to_run_spacing", mon_cyc - set_cyc, SETTLE + 1);
                    set_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
        tick();
        check("idle_after_reset", busy, 0);

        // Main sweep: 100,110,120,130 x2 runs
        run_full(100, 130, 10, 2, 1'b0);

        // Handshake timeout: sequencer never drops ready
        stuck = 1'b1;
        push_ev(1, 0, 0, 11, 1, 0, 0);
        push_ev(0, 1, 0, 11, 1, 0, 0);
        do_start(11, 11, 0, 1, 1'b1);
        n = 0;
        while (!bus.seq_run && n < 100) begin
            tick();
            n++;
        end
        check("run_seen", bus.seq_run, 1);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 1 + TMO);
        check("busy_after_timeout", busy, 0);
        repeat (5) tick();
        check("timeout_sticky", timeout_err, 1);
        check("timeout_queue_drained", exp_q.size(), 0);
        stuck = 1'b0;

        // Overflow boundary; the start also clears timeout_err
        push_scan(1020, 1023, 5, 1, 1'b0);
        do_start(1020, 1023, 5, 1, 1'b0);
        check("timeout_err_cleared", timeout_err, 0);
        wait_idle(3000);

        run_full(50, 40, 10, 1, 1'b1);
        run_full(7, 20, 0, 1, 1'b0);
        run_full(9, 9, 1, 0, 1'b1);

        // Abort during settle of the second point
        push_ev(1, 0, 0, 0, 0, 0, 0);
        push_ev(0, 1, 0, 0, 0, 0, 0);
        push_ev(1, 0, 0, 10, 0, 1, 0);
        do_start(0, 30, 10, 1, 1'b0);
        n = 0;
        while (!(bus.del_set && point_idx == 1) && n < 500) begin
            tick();
            n++;
        end
        check("second_point_seen", point_idx, 1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("busy_after_abort", busy, 0);
        check("abort_keeps_err", timeout_err, 0);
        repeat (40) tick();
        check("abort_queue_drained", exp_q.size(), 0);

        // start + abort together in idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", busy, 0);
        repeat (30) tick();

        // Config change and start while busy are ignored
        push_scan(200, 220, 10, 1, 1'b1);
        do_start(200, 220, 10, 1, 1'b1);
        repeat (8) tick();
        cfg_last  = 10'd500;
        cfg_first = 10'd3;
        cfg_step  = 10'd1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_idle(3000);

        // Synchronous reset while in WAIT_HIGH
        push_ev(1, 0, 0, 5, 1, 0, 0);
        push_ev(0, 1, 0, 5, 1, 0, 0);
        do_start(5, 25, 10, 3, 1'b1);
        n = 0;
        while (!bus.seq_run && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (bus.seq_ready && n < 20) begin
            tick();
            n++;
        end
        check("wait_high_reached", bus.seq_ready, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_mid_scan", outs(), 0);
        reset = 1'b0;
        tick();
        check("idle_after_mid_reset", busy, 0);
        check("reset_queue_drained", exp_q.size(), 0);
        run_full(3, 3, 1, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_scan_controller.md
Name: delay_scan_controller

Overview:
- Sweeps the 10-bit delay-chip setting across a configured range and runs the TDC sequencer a fixed number of times at each point.
- Sits between the command decoder and the `delay` / `sequencer_for_TDC_V1_SW_28_10_19` instances. It drives their set/sel/d and run_sequencer inputs in place of single SPI commands.
- Gives unattended delay-vs-code characterisation scans.

Parameters:
- DW, 10, delay code width
- SETTLE_CYCLES, 16, clk cycles to wait after a delay write before a run (>=1)
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for each sequencer handshake phase

Ports:
- clk  in  1  system clock (PLL c0)
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a scan
- abort  in  1  single-cycle pulse; stops a scan
- cfg_first  in  DW  first delay code
- cfg_last  in  DW  last delay code (inclusive)
- cfg_step  in  DW  code increment
- cfg_repeats  in  8  sequencer runs per point
- cfg_chip  in  1  delay chip select: 0=A, 1=B
- del_set  out  1  one-cycle pulse to `delay.set`
- del_sel  out  1  to `delay.sel`
- del_d  out  DW  to `delay.d`
- seq_run  out  1  one-cycle pulse to `run_sequencer`
- seq_ready  in  1  sequencer `ready_flag`
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse on normal completion
- timeout_err  out  1  sticky flag; handshake timed out
- point_idx  out  DW  index of the current point, 0-based
- run_idx  out  8  run index within the current point

Behaviour:
- Reset values: all outputs 0. State is IDLE. Latched config is 0.
- Config latching:
  - On start in IDLE, cfg_* are latched; later cfg changes have no effect on a running scan.
  - start while busy is ignored.
  - On start in IDLE, timeout_err clears.
- States:
  - IDLE -> PROGRAM on start.
  - PROGRAM (1 cycle): del_set=1; del_sel=chip; del_d=current code. -> SETTLE.
  - SETTLE: count SETTLE_CYCLES, then -> RUN.
  - RUN (1 cycle): seq_run=1. -> WAIT_LOW.
  - WAIT_LOW: wait for seq_ready=0 (sequencer accepted). -> WAIT_HIGH.
  - WAIT_HIGH: wait for seq_ready=1. -> NEXT.
  - NEXT, repeats remain: run_idx++ and -> RUN (no reprogram).
  - NEXT, repeats exhausted, more points: code+=step, point_idx++, run_idx=0, -> PROGRAM.
  - NEXT, repeats exhausted, last point: -> DONE.
  - DONE (1 cycle): done=1. -> IDLE.
- busy=1 in every state except IDLE.
- Latency: start to first del_set = 1 cycle. del_set to seq_run = SETTLE_CYCLES+1 cycles.
- Arithmetic:
  - The next code is computed DW+1 bits wide.
  - The scan ends if next > cfg_last, or if it overflows DW bits. No wrap-around.
  - cfg_step=0 or cfg_first>cfg_last: a single point at cfg_first.
  - cfg_repeats=0 is treated as 1.
- Timeout:
  - One shared counter, reset on entry to WAIT_LOW and on entry to WAIT_HIGH.
  - On reaching TIMEOUT_CYCLES: timeout_err=1 (sticky), -> IDLE. No done pulse.
- Abort:
  - Takes effect in any non-IDLE state: -> IDLE on the next edge.
  - del_set and seq_run are forced 0 in that cycle. No done pulse. timeout_err is unchanged.
  - Abort wins over start and over any pending transition.
  - The sequencer is not reset by this block.
- Simultaneous events:
  - seq_ready rising at timeout expiry in WAIT_HIGH: ready wins.
  - start and abort together in IDLE: no scan starts.
- Reset mid-scan returns to IDLE with reset values on the same edge.
- del_d holds its value between PROGRAM pulses. point_idx and run_idx hold their last values until the next start, then zero.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, PROGRAM, SETTLE, RUN, WAIT_LOW, WAIT_HIGH, NEXT, DONE)
  - the DW default
  - the cfg bundle typedef (first/last/step/repeats/chip), reused by the SPI command-decoder extension
- One sub-module: scan_wait_counter. It is a loadable down-counter with a terminal flag, used for both the settle and timeout waits.

Test Plan:
- Scan first=100, last=130, step=10, repeats=2, chip=0; sequencer model ready-low 3 cycles after run, high 20 cycles later -> del_d sequence 100,110,120,130. Four del_set pulses, each with del_sel=0. Eight seq_run pulses. One done pulse. busy falls the cycle after done.
- Boundary: first=1020, last=1023, step=5 -> single point 1020, then done. first=50, last=40 -> single point 50. step=0 -> single point. repeats=0 -> exactly one seq_run.
- Sequencer never drops ready, TIMEOUT_CYCLES=64 -> timeout_err=1 exactly 64 cycles after WAIT_LOW entry. busy=0, no done. The next start clears timeout_err.
- Abort during SETTLE of point 2 -> busy=0 next edge, no further del_set/seq_run, no done. Then start+abort in the same IDLE cycle -> stays idle.
- Mid-scan config and start: change cfg_last and assert start while busy -> the scan completes with the originally latched range. Check that del_set to seq_run spacing is exactly SETTLE_CYCLES+1 cycles.
- Reset: assert synchronous reset in WAIT_HIGH -> all outputs 0 on that edge, state IDLE. A start after release begins a fresh scan with point_idx=0.
